// File: rtl/mem_req_arbiter.sv
// Single-outstanding arbiter between icache fetches and LSB loads/stores toward a byte-serial
// memory controller. LSB has priority; a saturating counter forces a fetch through periodically.
module mem_req_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  // icache side
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_valid,
  output logic [31:0]       ic_data,
  // load/store buffer side
  input  logic              lsb_req,
  input  logic              lsb_wr,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [31:0]       lsb_wdata,
  input  logic [2:0]        lsb_len,
  input  logic              lsb_signed,
  output logic              lsb_valid,
  output logic [31:0]       lsb_rdata,
  // memory controller side
  output logic              mc_req,
  output logic              mc_wr,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [31:0]       mc_wdata,
  output logic [2:0]        mc_len,
  input  logic              mc_done,
  input  logic [31:0]       mc_rdata
);

  localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    StIdle,
    StBusyIc,
    StBusyLsb,
    StDrain
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   starve_q, starve_d;
  logic              mc_req_q, mc_req_d;
  logic              mc_wr_q, mc_wr_d;
  logic [ADDR_W-1:0] mc_addr_q, mc_addr_d;
  logic [31:0]       mc_wdata_q, mc_wdata_d;
  logic [2:0]        mc_len_q, mc_len_d;
  logic              signed_q, signed_d;
  logic              ic_valid_q, ic_valid_d;
  logic [31:0]       ic_data_q, ic_data_d;
  logic              lsb_valid_q, lsb_valid_d;
  logic [31:0]       lsb_rdata_q, lsb_rdata_d;

  logic arb_en;
  logic grant_lsb;
  logic grant_ic;

  // Sign/zero extension of the low bytes; unsupported lengths pass through untouched.
  function automatic logic [31:0] extend_load(input logic [31:0] d, input logic [2:0] len,
                                              input logic sgn);
    logic [31:0] r;
    case (len)
      3'd1:    r = {{24{sgn & d[7]}}, d[7:0]};
      3'd2:    r = {{16{sgn & d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Hold off arbitration while a response pulse is out so the requester can drop its req first.
  assign arb_en    = (state_q == StIdle) && !ic_valid_q && !lsb_valid_q;
  assign grant_lsb = lsb_req && !(ic_req && (starve_q == StarveMax));
  assign grant_ic  = !grant_lsb && ic_req && !flush;

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    mc_req_d    = 1'b0;
    mc_wr_d     = mc_wr_q;
    mc_addr_d   = mc_addr_q;
    mc_wdata_d  = mc_wdata_q;
    mc_len_d    = mc_len_q;
    signed_d    = signed_q;
    ic_valid_d  = 1'b0;
    ic_data_d   = ic_data_q;
    lsb_valid_d = 1'b0;
    lsb_rdata_d = lsb_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (!ic_req) begin
          starve_d = '0;
        end
        if (arb_en && grant_lsb) begin
          state_d    = StBusyLsb;
          mc_req_d   = 1'b1;
          mc_wr_d    = lsb_wr;
          mc_addr_d  = lsb_addr;
          mc_wdata_d = lsb_wdata;
          mc_len_d   = lsb_len;
          signed_d   = lsb_signed;
          if (ic_req && (starve_q != StarveMax)) begin
            starve_d = starve_q + CntW'(1);
          end
        end else if (arb_en && grant_ic) begin
          state_d    = StBusyIc;
          mc_req_d   = 1'b1;
          mc_wr_d    = 1'b0;
          mc_addr_d  = ic_addr;
          mc_wdata_d = '0;
          mc_len_d   = 3'd4;
          signed_d   = 1'b0;
          starve_d   = '0;
        end
      end
      StBusyIc: begin
        if (mc_done) begin
          state_d = StIdle;
          // A flush landing with the data still kills the response.
          if (!flush) begin
            ic_valid_d = 1'b1;
            ic_data_d  = mc_rdata;
          end
        end else if (flush) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (mc_done) begin
          state_d = StIdle;
        end
      end
      StBusyLsb: begin
        if (mc_done) begin
          state_d     = StIdle;
          lsb_valid_d = 1'b1;
          lsb_rdata_d = mc_wr_q ? 32'd0 : extend_load(mc_rdata, mc_len_q, signed_q);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (flush) begin
      starve_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      starve_q    <= '0;
      mc_req_q    <= 1'b0;
      mc_wr_q     <= 1'b0;
      mc_addr_q   <= '0;
      mc_wdata_q  <= '0;
      mc_len_q    <= '0;
      signed_q    <= 1'b0;
      ic_valid_q  <= 1'b0;
      ic_data_q   <= '0;
      lsb_valid_q <= 1'b0;
      lsb_rdata_q <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mc_req_q    <= mc_req_d;
      mc_wr_q     <= mc_wr_d;
      mc_addr_q   <= mc_addr_d;
      mc_wdata_q  <= mc_wdata_d;
      mc_len_q    <= mc_len_d;
      signed_q    <= signed_d;
      ic_valid_q  <= ic_valid_d;
      ic_data_q   <= ic_data_d;
      lsb_valid_q <= lsb_valid_d;
      lsb_rdata_q <= lsb_rdata_d;
    end
  end

  assign mc_req    = mc_req_q;
  assign mc_wr     = mc_wr_q;
  assign mc_addr   = mc_addr_q;
  assign mc_wdata  = mc_wdata_q;
  assign mc_len    = mc_len_q;
  assign ic_valid  = ic_valid_q;
  assign ic_data   = ic_data_q;
  assign lsb_valid = lsb_valid_q;
  assign lsb_rdata = lsb_rdata_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed corner cases, then randomized rounds scored against a
// transaction-level arbitration/extension model through expectation queues.
module tb_mem_req_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned LIM = 4;

  logic          clk = 1'b0;
  logic          rst, rdy, flush;
  logic          ic_req;
  logic [AW-1:0] ic_addr;
  logic          ic_valid;
  logic [31:0]   ic_data;
  logic          lsb_req, lsb_wr, lsb_signed;
  logic [AW-1:0] lsb_addr;
  logic [31:0]   lsb_wdata;
  logic [2:0]    lsb_len;
  logic          lsb_valid;
  logic [31:0]   lsb_rdata;
  logic          mc_req, mc_wr;
  logic [AW-1:0] mc_addr;
  logic [31:0]   mc_wdata;
  logic [2:0]    mc_len;
  logic          mc_done;
  logic [31:0]   mc_rdata;

  always #5 clk = ~clk;

  mem_req_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(LIM)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .flush      (flush),
    .ic_req     (ic_req),
    .ic_addr    (ic_addr),
    .ic_valid   (ic_valid),
    .ic_data    (ic_data),
    .lsb_req    (lsb_req),
    .lsb_wr     (lsb_wr),
    .lsb_addr   (lsb_addr),
    .lsb_wdata  (lsb_wdata),
    .lsb_len    (lsb_len),
    .lsb_signed (lsb_signed),
    .lsb_valid  (lsb_valid),
    .lsb_rdata  (lsb_rdata),
    .mc_req     (mc_req),
    .mc_wr      (mc_wr),
    .mc_addr    (mc_addr),
    .mc_wdata   (mc_wdata),
    .mc_len     (mc_len),
    .mc_done    (mc_done),
    .mc_rdata   (mc_rdata)
  );

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  len;
    logic        sgn;
  } op_t;

  typedef struct packed {
    logic is_ic;
    op_t  op;
  } grant_t;

  int checks   = 0;
  int failures = 0;

  // Scoreboard queues (pushed by stimulus side, popped by the monitor).
  grant_t      exp_grant_q[$];
  logic [31:0] exp_ic_q[$];
  logic [31:0] exp_lsb_q[$];

  // Stimulus-side state for the randomized phase.
  bit          auto_mode;
  grant_t      order_q[$];
  op_t         lsb_ops[$];
  bit          ic_pend;
  logic [31:0] ic_pend_addr;
  bit          mc_busy;
  int          mc_cnt;
  grant_t      cur;
  grant_t      mon_g;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expected load result from the extension rules, in plain arithmetic.
  function automatic logic [31:0] load_result(input op_t op, input logic [31:0] d);
    int unsigned v;
    if (op.wr) return 32'd0;
    if (op.len == 3'd1) begin
      v = d % 256;
      if (op.sgn && v >= 128) v = v - 256;
      return v;
    end
    if (op.len == 3'd2) begin
      v = d % 65536;
      if (op.sgn && v >= 32768) v = v - 65536;
      return v;
    end
    return d;
  endfunction

  task automatic wait_req(output bit got);
    got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (mc_req) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic mc_finish(input logic [31:0] d);
    mc_done  = 1'b1;
    mc_rdata = d;
    cyc();
    mc_done  = 1'b0;
  endtask

  task automatic lsb_txn(input string nm, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] len, input logic sgn,
                         input logic [31:0] rdata, input logic [31:0] exp, input bit do_flush);
    bit got;
    lsb_req = 1'b1; lsb_wr = wr; lsb_addr = addr; lsb_wdata = wdata;
    lsb_len = len; lsb_signed = sgn;
    wait_req(got);
    check({nm, " mc_req"}, 32'(got), 32'd1);
    check({nm, " mc_addr"}, mc_addr, addr);
    check({nm, " mc_len"}, 32'(mc_len), 32'(len));
    check({nm, " mc_wr"}, 32'(mc_wr), 32'(wr));
    if (wr) check({nm, " mc_wdata"}, mc_wdata, wdata);
    cyc();
    if (do_flush) flush = 1'b1;
    cyc();
    flush = 1'b0;
    mc_finish(rdata);
    check({nm, " lsb_valid"}, 32'(lsb_valid), 32'd1);
    check({nm, " lsb_rdata"}, lsb_rdata, exp);
    lsb_req = 1'b0;
    cyc();
    check({nm, " lsb_valid drop"}, 32'(lsb_valid), 32'd0);
  endtask

  // Randomized-phase driver: requesters, memory-controller model and rdy.
  always @(posedge clk) begin
    #1;
    if (auto_mode) begin
      mc_done = 1'b0;
      rdy = ($urandom_range(0, 4) != 0);
      if (rdy) begin
        if (lsb_valid && lsb_ops.size() > 0) lsb_ops.delete(0);
        if (ic_valid) ic_pend = 1'b0;
        if (mc_busy) begin
          mc_cnt--;
          if (mc_cnt == 0) begin
            mc_busy  = 1'b0;
            mc_done  = 1'b1;
            mc_rdata = $urandom();
            if (cur.is_ic) exp_ic_q.push_back(mc_rdata);
            else exp_lsb_q.push_back(load_result(cur.op, mc_rdata));
          end
        end
        if (mc_req && order_q.size() > 0) begin
          cur     = order_q.pop_front();
          mc_busy = 1'b1;
          mc_cnt  = $urandom_range(1, 4);
        end
      end
      ic_req  = ic_pend;
      ic_addr = ic_pend_addr;
      if (lsb_ops.size() > 0) begin
        lsb_req    = 1'b1;
        lsb_wr     = lsb_ops[0].wr;
        lsb_addr   = lsb_ops[0].addr;
        lsb_wdata  = lsb_ops[0].wdata;
        lsb_len    = lsb_ops[0].len;
        lsb_signed = lsb_ops[0].sgn;
      end else begin
        lsb_req = 1'b0;
      end
    end
  end

  // Monitor: every consumed mc_req / response pulse is matched against the queues.
  always @(negedge clk) begin
    if (auto_mode && rdy && !rst) begin
      if (mc_req) begin
        if (exp_grant_q.size() == 0) begin
          check("unexpected mc_req", 32'(mc_req), 32'd0);
        end else begin
          mon_g = exp_grant_q.pop_front();
          check("grant mc_addr", mc_addr, mon_g.op.addr);
          check("grant mc_len", 32'(mc_len), 32'(mon_g.op.len));
          check("grant mc_wr", 32'(mc_wr), 32'(mon_g.op.wr));
          if (mon_g.op.wr) check("grant mc_wdata", mc_wdata, mon_g.op.wdata);
        end
      end
      if (lsb_valid) begin
        if (exp_lsb_q.size() == 0) check("unexpected lsb_valid", 32'(lsb_valid), 32'd0);
        else check("lsb_rdata", lsb_rdata, exp_lsb_q.pop_front());
      end
      if (ic_valid) begin
        if (exp_ic_q.size() == 0) check("unexpected ic_valid", 32'(ic_valid), 32'd0);
        else check("ic_data", ic_data, exp_ic_q.pop_front());
      end
    end
  end

  initial begin
    bit     got;
    bit     abort;
    bit     has_ic;
    bit     icp;
    int     n;
    int     s;
    bit     done;
    op_t    op;
    op_t    ops[$];
    grant_t g;

    auto_mode = 1'b0; abort = 1'b0;
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    ic_req = 1'b0; ic_addr = '0;
    lsb_req = 1'b0; lsb_wr = 1'b0; lsb_addr = '0; lsb_wdata = '0; lsb_len = '0;
    lsb_signed = 1'b0; mc_done = 1'b0; mc_rdata = '0;
    ic_pend = 1'b0; ic_pend_addr = '0; mc_busy = 1'b0; mc_cnt = 0;
    cyc(); cyc();
    check("reset mc_req", 32'(mc_req), 32'd0);
    check("reset ic_valid", 32'(ic_valid), 32'd0);
    check("reset lsb_valid", 32'(lsb_valid), 32'd0);
    check("reset mc_addr", mc_addr, 32'd0);
    check("reset mc_len", 32'(mc_len), 32'd0);
    rst = 1'b0;

    // Single fetch.
    ic_req = 1'b1; ic_addr = 32'h100;
    wait_req(got);
    check("fetch mc_req", 32'(got), 32'd1);
    check("fetch mc_addr", mc_addr, 32'h100);
    check("fetch mc_len", 32'(mc_len), 32'd4);
    check("fetch mc_wr", 32'(mc_wr), 32'd0);
    repeat (4) cyc();
    mc_finish(32'hDEADBEEF);
    check("fetch ic_valid", 32'(ic_valid), 32'd1);
    check("fetch ic_data", ic_data, 32'hDEADBEEF);
    ic_req = 1'b0;
    cyc();
    check("fetch ic_valid pulse", 32'(ic_valid), 32'd0);

    // Load extension.
    lsb_txn("ldb signed", 1'b0, 32'h40, 32'h0, 3'd1, 1'b1, 32'h000000F0, 32'hFFFFFFF0, 1'b0);
    lsb_txn("ldb unsigned", 1'b0, 32'h41, 32'h0, 3'd1, 1'b0, 32'h000000F0, 32'h000000F0, 1'b0);
    lsb_txn("ldh signed", 1'b0, 32'h42, 32'h0, 3'd2, 1'b1, 32'h5A5A8001, 32'hFFFF8001, 1'b0);
    lsb_txn("ld len3", 1'b0, 32'h43, 32'h0, 3'd3, 1'b1, 32'h000000F0, 32'h000000F0, 1'b0);

    // Store with flush while busy.
    lsb_txn("st flush", 1'b1, 32'h80, 32'h1234ABCD, 3'd2, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b1);

    // Flush mid-fetch: drain, then the pending load is granted.
    ic_req = 1'b1; ic_addr = 32'h200;
    wait_req(got);
    check("drain fetch mc_req", 32'(got), 32'd1);
    cyc(); cyc();
    flush = 1'b1; ic_req = 1'b0;
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h300; lsb_len = 3'd4; lsb_signed = 1'b0;
    cyc();
    flush = 1'b0;
    got = 1'b0;
    repeat (3) begin
      cyc();
      if (mc_req) got = 1'b1;
    end
    check("drain holds off lsb", 32'(got), 32'd0);
    mc_finish(32'h11112222);
    check("drain no ic_valid", 32'(ic_valid), 32'd0);
    wait_req(got);
    check("drain then lsb mc_req", 32'(got), 32'd1);
    check("drain then lsb mc_addr", mc_addr, 32'h300);
    cyc();
    mc_finish(32'hCAFEF00D);
    check("drain lsb_rdata", lsb_rdata, 32'hCAFEF00D);
    lsb_req = 1'b0;
    cyc();

    // Flush coincident with mc_done.
    ic_req = 1'b1; ic_addr = 32'h204;
    wait_req(got);
    cyc();
    mc_done = 1'b1; mc_rdata = 32'h55555555; flush = 1'b1; ic_req = 1'b0;
    cyc();
    mc_done = 1'b0; flush = 1'b0;
    check("flush+done no ic_valid", 32'(ic_valid), 32'd0);
    lsb_txn("after flush+done", 1'b0, 32'h44, 32'h0, 3'd4, 1'b0, 32'h0BADF00D, 32'h0BADF00D,
            1'b0);

    // rdy low freezes a pending mc_req pulse.
    ic_req = 1'b1; ic_addr = 32'h208;
    wait_req(got);
    rdy = 1'b0;
    got = 1'b1;
    repeat (3) begin
      cyc();
      if (!mc_req) got = 1'b0;
    end
    check("rdy low holds mc_req", 32'(got), 32'd1);
    rdy = 1'b1;
    cyc();
    check("rdy high releases mc_req", 32'(mc_req), 32'd0);
    mc_finish(32'h76543210);
    check("rdy fetch ic_data", ic_data, 32'h76543210);
    ic_req = 1'b0;
    cyc();

    // Reset in the middle of a load; a late mc_done must be ignored.
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h500; lsb_len = 3'd4;
    wait_req(got);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0; lsb_req = 1'b0;
    check("midrst mc_addr", mc_addr, 32'd0);
    check("midrst ic_data", ic_data, 32'd0);
    check("midrst mc_req", 32'(mc_req), 32'd0);
    mc_finish(32'h99999999);
    check("late done no lsb_valid", 32'(lsb_valid), 32'd0);
    check("late done lsb_rdata", lsb_rdata, 32'd0);
    cyc();

    // Randomized rounds; round 0 is the held-request starvation scenario.
    auto_mode = 1'b1;
    for (int r = 0; r < 40 && !abort; r++) begin
      has_ic = (r == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      n      = (r == 0) ? 6 : int'($urandom_range(0, 6));
      if (!has_ic && n == 0) n = 1;
      @(negedge clk);
      ops.delete();
      for (int k = 0; k < n; k++) begin
        op.wr    = 1'($urandom_range(0, 1));
        op.addr  = $urandom();
        op.wdata = $urandom();
        op.sgn   = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 7))
          0, 1:    op.len = 3'd1;
          2, 3:    op.len = 3'd2;
          4, 5:    op.len = 3'd4;
          default: op.len = 3'($urandom_range(0, 7));
        endcase
        ops.push_back(op);
      end
      ic_pend_addr = $urandom();
      // LSB wins unless the fetch has waited through LIM consecutive LSB grants.
      s = 0; icp = has_ic;
      for (int k = 0; k < n; k++) begin
        if (icp && s == LIM) begin
          g.is_ic = 1'b1; g.op = '{1'b0, ic_pend_addr, 32'd0, 3'd4, 1'b0};
          order_q.push_back(g); exp_grant_q.push_back(g);
          icp = 1'b0; s = 0;
        end
        g.is_ic = 1'b0; g.op = ops[k];
        order_q.push_back(g); exp_grant_q.push_back(g);
        s = icp ? ((s < LIM) ? s + 1 : s) : 0;
      end
      if (icp) begin
        g.is_ic = 1'b1; g.op = '{1'b0, ic_pend_addr, 32'd0, 3'd4, 1'b0};
        order_q.push_back(g); exp_grant_q.push_back(g);
      end
      lsb_ops = ops;
      ic_pend = has_ic;
      done = 1'b0;
      for (int c = 0; c < 3000 && !done; c++) begin
        @(negedge clk);
        done = (lsb_ops.size() == 0) && !ic_pend && !mc_busy && (exp_grant_q.size() == 0) &&
               (exp_ic_q.size() == 0) && (exp_lsb_q.size() == 0);
      end
      if (!done) begin
        check("round timeout", 32'(done), 32'd1);
        abort = 1'b1;
      end
      repeat (2) @(negedge clk);
    end
    auto_mode = 1'b0;
    check("grants drained", 32'(exp_grant_q.size()), 32'd0);
    check("lsb responses drained", 32'(exp_lsb_q.size()), 32'd0);
    check("ic responses drained", 32'(exp_ic_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
